// File: rtl/expmul_scheduler_if.sv
// rtl/expmul_scheduler_if.sv - score-in / expmul-op-out handshake bundle for expmul_scheduler
//
// Purpose: groups the score-stage handshake, the expmul operation handshake
// and the row status outputs of expmul_scheduler into one interface.
//
// Signals:
//   score_vld_in    score stage has a valid score
//   score_in        score s_j, Q4.4 signed
//   score_rdy_out   scheduler can accept a score
//   em_vld_out      operation valid toward expmul
//   em_rdy_in       expmul ready
//   em_a_out        expmul a_in
//   em_b_out        expmul b_in
//   em_o_star_mode  1 = rescale O*, 0 = weight V
//   row_max_out     running row max m
//   key_idx_out     key in flight / next key
//   row_done        one-cycle pulse after the final WEIGHT of a row
//
// Modports: master = scheduler side, slave = score stage / expmul side.

`timescale 1ns/1ps

`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif

interface expmul_scheduler_if #(
  parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
  parameter int SCORE_W = 8
);
  localparam int KW = $clog2(SEQ_LEN);

  logic               score_vld_in;
  logic [SCORE_W-1:0] score_in;
  logic               score_rdy_out;
  logic               em_vld_out;
  logic               em_rdy_in;
  logic [SCORE_W-1:0] em_a_out;
  logic [SCORE_W-1:0] em_b_out;
  logic               em_o_star_mode;
  logic [SCORE_W-1:0] row_max_out;
  logic [KW-1:0]      key_idx_out;
  logic               row_done;

  modport master (
    input  score_vld_in, score_in, em_rdy_in,
    output score_rdy_out, em_vld_out, em_a_out, em_b_out, em_o_star_mode,
           row_max_out, key_idx_out, row_done
  );

  modport slave (
    output score_vld_in, score_in, em_rdy_in,
    input  score_rdy_out, em_vld_out, em_a_out, em_b_out, em_o_star_mode,
           row_max_out, key_idx_out, row_done
  );
endinterface

// File: rtl/expmul_scheduler.sv
// rtl/expmul_scheduler.sv - running-max tracker and RESCALE/WEIGHT op sequencer for expmul
//
// Purpose: accepts one Q4.4 score per key of a query row, tracks the running
// row maximum m, and issues up to two expmul operations per key:
//   RESCALE  a = m_old, b = m_new, mode = 1  (only when the max grew and key != 0)
//   WEIGHT   a = s,     b = m_new, mode = 0  (always)
//
// Ports:
//   clock   sole clock, rising edge
//   reset   asynchronous, active-low
//   bus     expmul_scheduler_if.master (score handshake, expmul op handshake,
//           row_max_out, key_idx_out, row_done)

`timescale 1ns/1ps

`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif

module expmul_scheduler #(
  parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
  parameter int SCORE_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  expmul_scheduler_if.master  bus
);

  localparam int                 KW        = $clog2(SEQ_LEN);
  localparam logic [KW-1:0]      LAST_KEY  = KW'(SEQ_LEN - 1);
  localparam logic [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESCALE = 2'd1,
    ST_WEIGHT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [SCORE_W-1:0] r_m;
  logic [SCORE_W-1:0] r_m_prev;
  logic [SCORE_W-1:0] r_s_reg;
  logic [KW-1:0]      r_key_idx;
  logic               r_row_done;

  logic               w_score_take;
  logic               w_weight_take;
  logic               w_last_key;
  logic               w_s_gt_m;
  logic [SCORE_W-1:0] w_m_new;

  logic               w_score_rdy;
  logic               w_em_vld;
  logic [SCORE_W-1:0] w_em_a;
  logic [SCORE_W-1:0] w_em_b;
  logic               w_em_mode;

  assign w_score_take  = (r_state == ST_IDLE) && bus.score_vld_in;
  assign w_weight_take = (r_state == ST_WEIGHT) && bus.em_rdy_in;
  assign w_last_key    = (r_key_idx == LAST_KEY);

  // Strict greater-than: an equal score leaves m unchanged, so no rescale.
  assign w_s_gt_m = $signed(bus.score_in) > $signed(r_m);
  assign w_m_new  = w_s_gt_m ? bus.score_in : r_m;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus op decode. Every output here depends only on registered
  // state, so a/b/mode stay stable for as long as expmul holds off.
  always_comb begin
    w_state_nxt = r_state;
    w_score_rdy = 1'b0;
    w_em_vld    = 1'b0;
    w_em_a      = '0;
    w_em_b      = '0;
    w_em_mode   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_score_rdy = 1'b1;
        if (bus.score_vld_in) begin
          // exp(0) = 1 makes the rescale a no-op when the max did not grow;
          // on key 0 the accumulator is still empty.
          if ((r_key_idx != '0) && w_s_gt_m) begin
            w_state_nxt = ST_RESCALE;
          end else begin
            w_state_nxt = ST_WEIGHT;
          end
        end
      end

      ST_RESCALE: begin
        w_em_vld  = 1'b1;
        w_em_a    = r_m_prev;
        w_em_b    = r_m;
        w_em_mode = 1'b1;
        if (bus.em_rdy_in) begin
          w_state_nxt = ST_WEIGHT;
        end
      end

      ST_WEIGHT: begin
        w_em_vld  = 1'b1;
        w_em_a    = r_s_reg;
        w_em_b    = r_m;
        w_em_mode = 1'b0;
        if (bus.em_rdy_in) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Score capture and row bookkeeping. Capture happens only in IDLE and the
  // row-end update only in WEIGHT, so the two writes to r_m never collide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_m        <= MIN_SCORE;
      r_m_prev   <= MIN_SCORE;
      r_s_reg    <= '0;
      r_key_idx  <= '0;
      r_row_done <= 1'b0;
    end else begin
      r_row_done <= w_weight_take && w_last_key;

      if (w_score_take) begin
        r_s_reg  <= bus.score_in;
        r_m_prev <= r_m;
        r_m      <= w_m_new;
      end

      if (w_weight_take) begin
        if (w_last_key) begin
          r_key_idx <= '0;
          r_m       <= MIN_SCORE;
        end else begin
          r_key_idx <= r_key_idx + KW'(1);
        end
      end
    end
  end

  assign bus.score_rdy_out  = w_score_rdy;
  assign bus.em_vld_out     = w_em_vld;
  assign bus.em_a_out       = w_em_a;
  assign bus.em_b_out       = w_em_b;
  assign bus.em_o_star_mode = w_em_mode;
  assign bus.row_max_out    = r_m;
  assign bus.key_idx_out    = r_key_idx;
  assign bus.row_done       = r_row_done;

endmodule

// File: tb/tb_expmul_scheduler.sv
// tb/tb_expmul_scheduler.sv - self-checking bench for expmul_scheduler

`timescale 1ns/1ps

module tb_expmul_scheduler;

  localparam int SEQ_LEN = 4;
  localparam int SCORE_W = 8;
  localparam int LIMIT   = 2000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  expmul_scheduler_if #(.SEQ_LEN(SEQ_LEN), .SCORE_W(SCORE_W)) bus ();

  expmul_scheduler #(.SEQ_LEN(SEQ_LEN), .SCORE_W(SCORE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       last;
  } op_t;

  op_t               exp_q[$];
  logic [7:0]        stim[$];
  logic signed [7:0] mdl_m;
  int                mdl_k;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: for each accepted score, list the ops the row algorithm needs.
  task automatic model_accept(input logic [7:0] s);
    logic signed [7:0] ss;
    logic signed [7:0] mn;
    op_t op;
    ss = s;
    mn = (ss > mdl_m) ? ss : mdl_m;
    if (mdl_k != 0 && ss > mdl_m) begin
      op.a = mdl_m; op.b = mn; op.mode = 1'b1; op.last = 1'b0;
      exp_q.push_back(op);
    end
    op.a = s; op.b = mn; op.mode = 1'b0; op.last = (mdl_k == SEQ_LEN - 1);
    exp_q.push_back(op);
    mdl_m = mn;
    mdl_k++;
    if (mdl_k == SEQ_LEN) begin
      mdl_k = 0;
      mdl_m = 8'h80;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_m = 8'h80;
    mdl_k = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".score_rdy"}, bus.score_rdy_out, 1);
    chk({tag, ".em_vld"},    bus.em_vld_out, 0);
    chk({tag, ".em_a"},      bus.em_a_out, 0);
    chk({tag, ".em_b"},      bus.em_b_out, 0);
    chk({tag, ".mode"},      bus.em_o_star_mode, 0);
    chk({tag, ".row_max"},   bus.row_max_out, 8'h80);
    chk({tag, ".row_done"},  bus.row_done, 0);
    chk({tag, ".key_idx"},   bus.key_idx_out, 0);
  endtask

  task automatic reset_dut(input string tag);
    @(posedge clock);
    #2;
    reset = 1'b0;
    bus.score_vld_in = 1'b0;
    bus.score_in     = '0;
    bus.em_rdy_in    = 1'b1;
    #1;
    chk_reset_state({tag, ".in_reset"});
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_reset_state({tag, ".after_reset"});
  endtask

  // Streams stim[] with score_vld_in held high, em_rdy_in stalled at random
  // with probability stall_pct, checking every cycle against the model.
  task automatic run_scores(input string tag, input int stall_pct, input bit check_tput);
    int idx     = 0;
    int cyc     = 0;
    int last_hs = 0;
    int exp_cyc = 0;
    int n0;
    bit done_next = 1'b0;
    while ((idx < stim.size() || exp_q.size() != 0) && cyc < LIMIT) begin
      @(posedge clock);
      #1;
      cyc++;
      bus.score_vld_in = (idx < stim.size());
      bus.score_in     = (idx < stim.size()) ? stim[idx] : 8'($urandom);
      bus.em_rdy_in    = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clock);
      chk({tag, ".row_done"}, bus.row_done, done_next);
      done_next = 1'b0;
      chk({tag, ".em_vld"},    bus.em_vld_out, exp_q.size() != 0);
      chk({tag, ".score_rdy"}, bus.score_rdy_out, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        chk({tag, ".em_a"}, bus.em_a_out, exp_q[0].a);
        chk({tag, ".em_b"}, bus.em_b_out, exp_q[0].b);
        chk({tag, ".mode"}, bus.em_o_star_mode, exp_q[0].mode);
        if (bus.em_vld_out && bus.em_rdy_in) begin
          done_next = exp_q[0].last;
          void'(exp_q.pop_front());
          last_hs = cyc;
        end
      end else begin
        chk({tag, ".row_max"}, bus.row_max_out, {24'b0, mdl_m});
        chk({tag, ".key_idx"}, bus.key_idx_out, mdl_k);
        if (bus.score_vld_in && bus.score_rdy_out) begin
          n0 = exp_q.size();
          model_accept(stim[idx]);
          exp_cyc += exp_q.size() - n0 + 1;
          idx++;
        end
      end
    end
    chk({tag, ".in_budget"}, cyc < LIMIT, 1);
    if (check_tput) chk({tag, ".cycles"}, last_hs, exp_cyc);
    bus.score_vld_in = 1'b0;
    bus.em_rdy_in    = 1'b1;
    @(negedge clock);
    chk({tag, ".end_row_done"}, bus.row_done, done_next);
    chk({tag, ".end_em_vld"},   bus.em_vld_out, 0);
    chk({tag, ".end_row_max"},  bus.row_max_out, {24'b0, mdl_m});
    chk({tag, ".end_key_idx"},  bus.key_idx_out, mdl_k);
  endtask

  initial begin
    bus.score_vld_in = 1'b0;
    bus.score_in     = '0;
    bus.em_rdy_in    = 1'b1;
    model_reset();

    // Reset values
    reset_dut("rst");

    // First key: one WEIGHT (0x10, 0x10), then max 0x10, key 1
    stim = {8'h10};
    run_scores("first", 0, 1'b1);
    chk("first.row_max_lit", bus.row_max_out, 8'h10);
    chk("first.key_idx_lit", bus.key_idx_out, 1);

    // Increasing max: key 1 rescales
    reset_dut("inc.rst");
    stim = {8'h10, 8'h20};
    run_scores("inc", 0, 1'b1);

    // Equal and negative scores: weight only, signed compare keeps 0x20
    reset_dut("neg.rst");
    stim = {8'h20, 8'h20, 8'hF0};
    run_scores("neg", 0, 1'b1);
    chk("neg.row_max_lit", bus.row_max_out, 8'h20);

    // Backpressure during RESCALE, with score_vld_in held high throughout
    reset_dut("bp.rst");
    stim = {8'h10};
    run_scores("bp.pre", 0, 1'b0);
    @(posedge clock); #1;
    bus.score_vld_in = 1'b1;
    bus.score_in     = 8'h20;
    bus.em_rdy_in    = 1'b0;
    @(posedge clock); #1;
    bus.score_in = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      chk("bp.em_vld",    bus.em_vld_out, 1);
      chk("bp.em_a",      bus.em_a_out, 8'h10);
      chk("bp.em_b",      bus.em_b_out, 8'h20);
      chk("bp.mode",      bus.em_o_star_mode, 1);
      chk("bp.score_rdy", bus.score_rdy_out, 0);
      @(posedge clock); #1;
    end
    bus.em_rdy_in = 1'b1;
    chk("bp.still_rescale", bus.em_o_star_mode, 1);
    @(posedge clock); #1;
    chk("bp.w_vld",  bus.em_vld_out, 1);
    chk("bp.w_mode", bus.em_o_star_mode, 0);
    chk("bp.w_a",    bus.em_a_out, 8'h20);
    chk("bp.w_b",    bus.em_b_out, 8'h20);
    bus.score_vld_in = 1'b0;
    @(posedge clock); #1;
    chk("bp.idle_vld",   bus.em_vld_out, 0);
    chk("bp.idle_rdy",   bus.score_rdy_out, 1);
    chk("bp.key_idx",    bus.key_idx_out, 2);
    chk("bp.row_max",    bus.row_max_out, 8'h20);

    // Row wrap: two full rows back to back
    reset_dut("wrap.rst");
    stim = {8'h30, 8'h10, 8'h50, 8'h20, 8'hC0, 8'h60, 8'h10, 8'h70};
    run_scores("wrap", 0, 1'b1);

    // Reset while in RESCALE at key 2
    reset_dut("mid.rst");
    stim = {8'h10, 8'h20};
    run_scores("mid.pre", 0, 1'b0);
    @(posedge clock); #1;
    bus.score_vld_in = 1'b1;
    bus.score_in     = 8'h30;
    bus.em_rdy_in    = 1'b0;
    @(posedge clock); #1;
    bus.score_vld_in = 1'b0;
    chk("mid.in_rescale_vld",  bus.em_vld_out, 1);
    chk("mid.in_rescale_mode", bus.em_o_star_mode, 1);
    chk("mid.in_rescale_key",  bus.key_idx_out, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid.async_vld", bus.em_vld_out, 0);
    chk("mid.async_rdy", bus.score_rdy_out, 1);
    @(posedge clock); #2;
    reset = 1'b1;
    bus.em_rdy_in = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("mid.row_done", bus.row_done, 0);
      chk("mid.key_idx",  bus.key_idx_out, 0);
      chk("mid.row_max",  bus.row_max_out, 8'h80);
      chk("mid.rdy",      bus.score_rdy_out, 1);
    end

    // Random scores with random backpressure, then a stall-free random run
    reset_dut("rnd.rst");
    stim.delete();
    for (int i = 0; i < 22; i++) stim.push_back(8'($urandom));
    run_scores("rnd.stall", 30, 1'b0);
    stim.delete();
    for (int i = 0; i < 13; i++) stim.push_back(8'($urandom));
    run_scores("rnd.free", 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expmul_scheduler.md
# expmul_scheduler

Sequences the two-stage exponential-multiply datapath for one query row of the FlashAttention pipeline. Accepts one Q4.4 score per key from the score stage and tracks the running row maximum. For each key it issues up to two operations to the expmul datapath: a rescale of the O* accumulator by exp(m_old − m_new), then a weighting of V by exp(s − m_new). It sits between the QK score stage and the expmul stage and drives that stage's `a_in`, `b_in` and `o_star_mode` inputs plus its valid/ready handshake.

## Interface

Parameters:
- `SEQ_LEN`, default `` `MAX_SEQ_LENGTH `` (64): keys per query row; ≥ 2.
- `SCORE_W`, default 8: score width, Q4.4 two's complement.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; state clears immediately on assertion (0) and runs on the first edge after release.
- `score_vld_in`  in  1  score stage has a valid score.
- `score_in`  in  SCORE_W  score s_j, Q4.4 signed.
- `score_rdy_out`  out  1  scheduler can accept a score.
- `em_vld_out`  out  1  operation valid toward expmul.
- `em_rdy_in`  in  1  expmul `rdy_out`.
- `em_a_out`  out  SCORE_W  expmul `a_in`.
- `em_b_out`  out  SCORE_W  expmul `b_in`.
- `em_o_star_mode`  out  1  1 = rescale O*, 0 = weight V.
- `row_max_out`  out  SCORE_W  current running max m.
- `key_idx_out`  out  $clog2(SEQ_LEN)  index of key in flight / next key.
- `row_done`  out  1  one-cycle pulse after the final WEIGHT of a row handshakes.

## Operation

- State registers: `m` (running max), `m_prev`, `s_reg`, `key_idx`, FSM state.
- States: IDLE, RESCALE, WEIGHT.
- All comparisons are signed. `MIN_SCORE` = 0x80 (−8.0). There is no saturation: `max` is always exact.

FSM:
- IDLE: `score_rdy_out` = 1, `em_vld_out` = 0. On `score_vld_in`:
  - latch `s_reg` ← s, `m_prev` ← m, m ← max(m, s).
  - If `key_idx` == 0 or s ≤ m, go to WEIGHT. Skipping RESCALE is exact because exp(0) = 1; for the first key the accumulator is empty.
  - Otherwise go to RESCALE.
- RESCALE: `em_vld_out` = 1, `em_a_out` = `m_prev`, `em_b_out` = m, `em_o_star_mode` = 1. On `em_rdy_in`, go to WEIGHT.
- WEIGHT: `em_vld_out` = 1, `em_a_out` = `s_reg`, `em_b_out` = m, `em_o_star_mode` = 0. On `em_rdy_in`:
  - If `key_idx` == SEQ_LEN−1: `key_idx` ← 0, m ← `MIN_SCORE`, `row_done` = 1 on the next cycle.
  - Else: `key_idx` ← `key_idx` + 1.
  - Go to IDLE.
- `score_rdy_out` = 0 in RESCALE and WEIGHT. There is no skid buffer.
- While `em_vld_out` = 1 and `em_rdy_in` = 0, `em_a_out`, `em_b_out` and `em_o_star_mode` hold stable.
- Outputs are registered or decoded from registered state only; there is no combinational path from `score_in` or `em_rdy_in` to any output.

## Timing

- Reset values:
  - state IDLE, m = 0x80, `m_prev` = 0x80, `s_reg` = 0, `key_idx` = 0.
  - `score_rdy_out` = 1, `em_vld_out` = 0, `em_a_out` = 0, `em_b_out` = 0, `em_o_star_mode` = 0, `row_max_out` = 0x80, `row_done` = 0.
- Latency: a score accepted at edge N produces `em_vld_out` = 1 from cycle N+1.
- Throughput with no backpressure:
  - 2 cycles/score without rescale (IDLE, WEIGHT).
  - 3 cycles/score with rescale (IDLE, RESCALE, WEIGHT).
- `row_done` is high for exactly the cycle after the final WEIGHT handshake, coincident with IDLE. A new row's first score may be accepted in that same cycle.
- Reset asserted mid-operation: the FSM returns to IDLE with all registers at reset values and `em_vld_out` drops asynchronously. The partial row is discarded and no `row_done` is produced.
- `key_idx` wraps only at SEQ_LEN−1 → 0. It never reaches SEQ_LEN.
- `score_vld_in` held high across non-IDLE cycles has no effect; no score is consumed.

## Test plan

- First key: SEQ_LEN=4, send s=0x10 at key 0 with `em_rdy_in`=1. Expect exactly one op: a=0x10, b=0x10, mode=0; then `row_max_out`=0x10, `key_idx_out`=1.
- Increasing max: scores 0x10, 0x20. Key 1 produces RESCALE (a=0x10, b=0x20, mode=1) followed by WEIGHT (a=0x20, b=0x20, mode=0).
- Non-increasing and negative values: scores 0x20, 0x20, 0xF0 (−1.0). Keys 1 and 2 produce WEIGHT only: (0x20, 0x20) and (0xF0, 0x20). m stays 0x20; the signed compare is exercised.
- Backpressure: hold `em_rdy_in`=0 for 5 cycles during RESCALE. `em_vld_out`, a, b and mode stay constant; `score_rdy_out`=0 throughout; the transition to WEIGHT occurs one cycle after `em_rdy_in` rises.
- Row wrap: SEQ_LEN=4, stream 8 scores back-to-back. `row_done` pulses once after key 3 and once after key 7. m resets to 0x80, so key 4 produces WEIGHT only with b = s4.
- Reset mid-row: assert `reset`=0 while in RESCALE at key 2. `em_vld_out` drops without waiting for a clock. After release: `key_idx_out`=0, `row_max_out`=0x80, `score_rdy_out`=1, and no `row_done` pulse.
